imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Arbitrates the single-port 8K x 32 instruction memory between two requesters: the fetch stage (read-only) and the program loader/debug port (read/write). It sits between the core's fetch unit and the instruction memory array. It issues at most one memory access per cycle and routes each synchronous read response back to the requester that issued it. It also provides a loader lock so a program download cannot interleave with instruction fetch.

## Interface
- ADDR_W, 13, word-index width of the memory (8192 words)
- DATA_W, 32, data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch read request
- f_addr  in  32  fetch byte address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetch read data
- f_err  out  1  one-cycle pulse: accepted fetch was misaligned (addr[1:0]!=0)
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  32  loader byte address
- l_wdata  in  DATA_W  loader write data
- l_lock  in  1  loader requests exclusive ownership
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  loader read data valid
- l_rdata  out  DATA_W  loader read data
- locked  out  1  lock currently held by loader
- mem_addr  out  ADDR_W  word index to memory
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re

## Operation
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored.
- Each cycle, at most one of f_gnt/l_gnt is high. A grant is combinational from the req inputs and the current state.
- Lock FSM has two states:
  - OPEN: arbitration between requesters. OPEN -> LOCKED when l_lock=1 and no read response is pending.
  - LOCKED: only the loader is granted; f_gnt=0. LOCKED -> OPEN when l_lock=0.
- Arbitration in OPEN: round-robin. A 1-bit last_winner register updates on every grant. When both requesters are asserted, the one that did not win last is granted. A sole requester is always granted.
- Response routing:
  - A 1-bit owner register plus a pending flag record each accepted read.
  - The cycle after the grant, the owner's rvalid=1 and its rdata=mem_rdata.
  - Loader writes produce no rvalid.
- Misaligned fetch: it is still granted and performed at the truncated index, and f_err pulses in the same cycle as f_rvalid.
- Misaligned loader access: the low bits are silently dropped.
- mem_re = granted read. mem_we = granted loader write. mem_wdata = l_wdata.

## Timing
- Reset values: f_gnt, l_gnt, f_rvalid, l_rvalid, f_err, locked, mem_re, mem_we = 0. f_rdata, l_rdata, mem_addr, mem_wdata = 0. FSM = OPEN. last_winner = loader, so fetch wins the first tie.
- Grant to rvalid latency: exactly 1 cycle. Requests are fully pipelined, so back-to-back grants give back-to-back rvalids.
- Requesters hold req and addr until gnt. Rvalid is not backpressured.
- A grant in cycle N with lock assertion in N: the lock is taken in N+1 only after the N read response has returned. locked goes high in the cycle the FSM is LOCKED.
- Reset mid-operation: any pending response is discarded, and no rvalid is issued after reset deasserts.
- Loader write followed by a fetch read of the same index in the next cycle returns the new data (the memory is write-first).

## Configuration
- IMEM_ARB_LOADER_PRIO_EN
  - Defined: in OPEN the loader always wins ties over fetch; last_winner is unused.
  - Undefined: round-robin as described above.
  - Lock behaviour is identical in both cases.

## Structure
- A shared package imem_pkg holds ADDR_W/DATA_W defaults, the lock-state enum (LK_OPEN, LK_LOCKED) and the requester-ID encoding (REQ_FETCH=0, REQ_LOADER=1).
- One sub-module, imem_rr_arb2: a 2-way round-robin grant with last_winner storage and a priority-override input for the macro.
- Lock FSM and response routing stay in the top module.

## Test plan
- Reset, then f_req=1, f_addr=0x8 -> f_gnt=1 in the same cycle, mem_addr=2, mem_re=1; f_rvalid=1 next cycle with f_rdata=memory word 2.
- Both requesting for 4 cycles (round-robin build) -> grants alternate F, L, F, L; each rvalid goes only to its owner, one cycle after its grant.
- Same stimulus with IMEM_ARB_LOADER_PRIO_EN defined -> l_gnt=1 for all 4 cycles and f_gnt=0 throughout.
- l_lock=1 with fetch read pending -> locked rises only after f_rvalid. Then loader writes 0xDEADBEEF to index 5 with f_req=1 -> f_gnt stays 0. Drop l_lock, fetch index 5 -> f_rdata=0xDEADBEEF.
- f_addr=0x6 -> granted, mem_addr=1, f_err=1 coincident with f_rvalid.
- Assert rst_n=0 the cycle after a granted read -> no rvalid; all outputs return to their reset values; FSM=OPEN.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: default geometry,
// lock-state encoding and requester identifiers.
package imem_pkg;

  localparam int IMEM_ADDR_W = 13;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic {
    LK_OPEN   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

  typedef enum logic {
    REQ_FETCH  = 1'b0,
    REQ_LOADER = 1'b1
  } req_id_e;

endpackage

// File: rtl/imem_rr_arb2.sv
// Two-way round-robin grant (bit 0 = fetch, bit 1 = loader) with a
// loader-priority override that bypasses the stored last winner on ties.
module imem_rr_arb2
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  req_id_e lastWinner_q, lastWinner_d;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      if (prio_i || lastWinner_q == REQ_FETCH) gnt_o = 2'b10;
      else                                     gnt_o = 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

  always_comb begin
    lastWinner_d = lastWinner_q;
    if (gnt_o[1])      lastWinner_d = REQ_LOADER;
    else if (gnt_o[0]) lastWinner_d = REQ_FETCH;
  end

  // Reset to loader so that fetch wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lastWinner_q <= REQ_LOADER;
    else        lastWinner_q <= lastWinner_d;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between fetch and loader, with a
// loader lock. Define IMEM_ARB_LOADER_PRIO_EN to make the loader win all ties.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              locked,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lock_state_e lockState_q;
  logic        pend_q;
  req_id_e     owner_q;
  logic        fErr_q;
  logic [1:0]  arbReq;
  logic [1:0]  arbGnt;
  logic        prioLoader;
  logic        unusedAddr;

`ifdef IMEM_ARB_LOADER_PRIO_EN
  assign prioLoader = 1'b1;
`else
  assign prioLoader = 1'b0;
`endif

  assign locked = (lockState_q == LK_LOCKED);
  // Fetch is masked out while locked; no grants are issued while in reset.
  assign arbReq = {l_req, f_req & ~locked} & {2{rst_n}};

  imem_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (arbReq),
    .prio_i (prioLoader),
    .gnt_o  (arbGnt)
  );

  assign f_gnt     = arbGnt[0];
  assign l_gnt     = arbGnt[1];
  assign mem_re    = f_gnt | (l_gnt & ~l_we);
  assign mem_we    = l_gnt & l_we;
  assign mem_wdata = mem_we ? l_wdata : '0;
  assign mem_addr  = f_gnt ? f_addr[ADDR_W+1:2] :
                     l_gnt ? l_addr[ADDR_W+1:2] : '0;

  assign f_rvalid = pend_q & (owner_q == REQ_FETCH);
  assign l_rvalid = pend_q & (owner_q == REQ_LOADER);
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rvalid ? mem_rdata : '0;
  assign f_err    = f_rvalid & fErr_q;

  assign unusedAddr = ^{f_addr[31:ADDR_W+2], l_addr[31:ADDR_W+2], l_addr[1:0]};

  // Lock is taken only in a cycle that issues no read, so nothing is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockState_q <= LK_OPEN;
      pend_q      <= 1'b0;
      owner_q     <= REQ_FETCH;
      fErr_q      <= 1'b0;
    end else begin
      case (lockState_q)
        LK_OPEN:   if (l_lock && !mem_re) lockState_q <= LK_LOCKED;
        LK_LOCKED: if (!l_lock)           lockState_q <= LK_OPEN;
        default:                          lockState_q <= LK_OPEN;
      endcase
      pend_q  <= mem_re;
      owner_q <= l_gnt ? REQ_LOADER : REQ_FETCH;
      fErr_q  <= f_gnt & (f_addr[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Table-driven bench for imem_arbiter with a write-first memory model;
// expectations follow IMEM_ARB_LOADER_PRIO_EN when it is defined.
module tb_imem_arbiter;

`ifdef IMEM_ARB_LOADER_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk, rst_n;
  logic        f_req, l_req, l_we, l_lock;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, locked, mem_re, mem_we;
  logic [31:0] f_rdata, l_rdata, mem_wdata, mem_rdata;
  logic [12:0] mem_addr;

  logic [31:0] memArray [0:8191];
  int          assertCount = 0;
  int          failCount   = 0;

  typedef struct {
    logic        fReq;
    logic [31:0] fAddr;
    logic        lReq;
    logic        lWe;
    logic [31:0] lAddr;
    logic [31:0] lWdata;
    logic        lLock;
    logic        eFGnt;
    logic        eLGnt;
    logic [12:0] eMemAddr;
    logic        eMemRe;
    logic        eMemWe;
    logic        eFRvalid;
    logic        eLRvalid;
    logic [31:0] eFRdata;
    logic [31:0] eLRdata;
    logic        eFErr;
    logic        eLocked;
  } vec_t;

  imem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .locked(locked), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory, data one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_we) memArray[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= memArray[mem_addr];
  end

  function automatic vec_t makeVec(
    input logic fReq, input logic [31:0] fAddr, input logic lReq, input logic lWe,
    input logic [31:0] lAddr, input logic [31:0] lWdata, input logic lLock,
    input logic eFGnt, input logic eLGnt, input logic [12:0] eMemAddr,
    input logic eMemRe, input logic eMemWe, input logic eFRvalid, input logic eLRvalid,
    input logic [31:0] eFRdata, input logic [31:0] eLRdata, input logic eFErr,
    input logic eLocked);
    vec_t v;
    v.fReq = fReq; v.fAddr = fAddr; v.lReq = lReq; v.lWe = lWe;
    v.lAddr = lAddr; v.lWdata = lWdata; v.lLock = lLock;
    v.eFGnt = eFGnt; v.eLGnt = eLGnt; v.eMemAddr = eMemAddr;
    v.eMemRe = eMemRe; v.eMemWe = eMemWe; v.eFRvalid = eFRvalid;
    v.eLRvalid = eLRvalid; v.eFRdata = eFRdata; v.eLRdata = eLRdata;
    v.eFErr = eFErr; v.eLocked = eLocked;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector just after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    f_req = v.fReq; f_addr = v.fAddr; l_req = v.lReq; l_we = v.lWe;
    l_addr = v.lAddr; l_wdata = v.lWdata; l_lock = v.lLock;
  endtask

  // Sample on the falling edge; data fields only where they are defined.
  task automatic checkOutput(input string tag, input vec_t v);
    @(negedge clk);
    checkVal({tag, ".f_gnt"},    32'(f_gnt),    32'(v.eFGnt));
    checkVal({tag, ".l_gnt"},    32'(l_gnt),    32'(v.eLGnt));
    checkVal({tag, ".mem_re"},   32'(mem_re),   32'(v.eMemRe));
    checkVal({tag, ".mem_we"},   32'(mem_we),   32'(v.eMemWe));
    checkVal({tag, ".f_rvalid"}, 32'(f_rvalid), 32'(v.eFRvalid));
    checkVal({tag, ".l_rvalid"}, 32'(l_rvalid), 32'(v.eLRvalid));
    checkVal({tag, ".f_err"},    32'(f_err),    32'(v.eFErr));
    checkVal({tag, ".locked"},   32'(locked),   32'(v.eLocked));
    if (v.eFGnt || v.eLGnt) checkVal({tag, ".mem_addr"}, 32'(mem_addr), 32'(v.eMemAddr));
    if (v.eMemWe)   checkVal({tag, ".mem_wdata"}, mem_wdata, v.lWdata);
    if (v.eFRvalid) checkVal({tag, ".f_rdata"},   f_rdata,   v.eFRdata);
    if (v.eLRvalid) checkVal({tag, ".l_rdata"},   l_rdata,   v.eLRdata);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".f_gnt"},     32'(f_gnt),    0);
    checkVal({tag, ".l_gnt"},     32'(l_gnt),    0);
    checkVal({tag, ".f_rvalid"},  32'(f_rvalid), 0);
    checkVal({tag, ".l_rvalid"},  32'(l_rvalid), 0);
    checkVal({tag, ".f_err"},     32'(f_err),    0);
    checkVal({tag, ".locked"},    32'(locked),   0);
    checkVal({tag, ".mem_re"},    32'(mem_re),   0);
    checkVal({tag, ".mem_we"},    32'(mem_we),   0);
    checkVal({tag, ".f_rdata"},   f_rdata,       0);
    checkVal({tag, ".l_rdata"},   l_rdata,       0);
    checkVal({tag, ".mem_addr"},  32'(mem_addr), 0);
    checkVal({tag, ".mem_wdata"}, mem_wdata,     0);
  endtask

  vec_t table_q [12];
  vec_t seq_q [7];

  initial begin
    for (int i = 0; i < 8192; i++) memArray[i] = 32'h1000_0000 + 32'(i);
    mem_rdata = '0;
    rst_n = 1'b0;
    f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_lock = 0;

    table_q[0]  = makeVec(1, 32'h8, 0, 0, 0, 0, 0,  1, 0, 13'd2, 1, 0,  0, 0, 0, 0, 0, 0);
    table_q[1]  = makeVec(0, 0, 1, 0, 32'h4, 0, 0,  0, 1, 13'd1, 1, 0,  1, 0, 32'h1000_0002, 0, 0, 0);
    table_q[2]  = makeVec(1, 32'h10, 1, 0, 32'h20, 0, 0,  !PRIO, PRIO, PRIO ? 13'd8 : 13'd4, 1, 0,
                          0, 1, 0, 32'h1000_0001, 0, 0);
    table_q[3]  = makeVec(1, 32'h10, 1, 0, 32'h20, 0, 0,  0, 1, 13'd8, 1, 0,
                          !PRIO, PRIO, 32'h1000_0004, 32'h1000_0008, 0, 0);
    table_q[4]  = table_q[2];
    table_q[4].eLRvalid = 1'b1; table_q[4].eLRdata = 32'h1000_0008;
    table_q[5]  = table_q[3];
    table_q[6]  = makeVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 32'h1000_0008, 0, 0);
    table_q[7]  = makeVec(1, 32'h6, 0, 0, 0, 0, 0,  1, 0, 13'd1, 1, 0,  0, 0, 0, 0, 0, 0);
    table_q[8]  = makeVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 32'h1000_0001, 0, 1, 0);
    table_q[9]  = makeVec(0, 0, 1, 1, 32'h40, 32'hCAFE_F00D, 0,  0, 1, 13'd16, 0, 1,  0, 0, 0, 0, 0, 0);
    table_q[10] = makeVec(1, 32'hFFFF_0040, 0, 0, 0, 0, 0,  1, 0, 13'd16, 1, 0,  0, 0, 0, 0, 0, 0);
    table_q[11] = makeVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 32'hCAFE_F00D, 0, 0, 0);

    seq_q[0] = makeVec(1, 32'hC, 0, 0, 0, 0, 1,  1, 0, 13'd3, 1, 0,  0, 0, 0, 0, 0, 0);
    seq_q[1] = makeVec(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  1, 0, 32'h1000_0003, 0, 0, 0);
    seq_q[2] = makeVec(1, 32'h14, 1, 1, 32'h14, 32'hDEAD_BEEF, 1,  0, 1, 13'd5, 0, 1,  0, 0, 0, 0, 0, 1);
    seq_q[3] = makeVec(1, 32'h14, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    seq_q[4] = makeVec(1, 32'h14, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    seq_q[5] = makeVec(1, 32'h14, 0, 0, 0, 0, 0,  1, 0, 13'd5, 1, 0,  0, 0, 0, 0, 0, 0);
    seq_q[6] = makeVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 32'hDEAD_BEEF, 0, 0, 0);

    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(table_q[i]);
      checkOutput($sformatf("row%0d", i), table_q[i]);
    end

    for (int i = 0; i < 7; i++) begin
      applyStimulus(seq_q[i]);
      checkOutput($sformatf("lock%0d", i), seq_q[i]);
    end

    // Take the lock, issue a loader read, then reset while it is in flight.
    applyStimulus(makeVec(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    checkOutput("rst0", makeVec(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    applyStimulus(makeVec(0, 0, 1, 0, 32'h8, 0, 1,  0, 1, 13'd2, 1, 0,  0, 0, 0, 0, 0, 1));
    checkOutput("rst1", makeVec(0, 0, 1, 0, 32'h8, 0, 1,  0, 1, 13'd2, 1, 0,  0, 0, 0, 0, 0, 1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    f_req = 0; l_req = 0; l_lock = 0;
    #2;
    checkAllZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(makeVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    checkOutput("post0", makeVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    applyStimulus(makeVec(1, 32'h0, 0, 0, 0, 0, 0,  1, 0, 13'd0, 1, 0,  0, 0, 0, 0, 0, 0));
    checkOutput("post1", makeVec(1, 32'h0, 0, 0, 0, 0, 0,  1, 0, 13'd0, 1, 0,  0, 0, 0, 0, 0, 0));
    applyStimulus(makeVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 32'h1000_0000, 0, 0, 0));
    checkOutput("post2", makeVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 32'h1000_0000, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
